mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 63 ++++++
 rtl/mem_arb.sv | 110 +++++++++++
 tb/tb_mem_arb.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Handshake bundle between the two cache requesters, the memory port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arb_if #(
    parameter int ADDR_W = 59,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_valid;
    logic              ic_req_retry;

    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_we;
    logic [LINE_W-1:0] dc_req_data;
    logic              dc_req_valid;
    logic              dc_req_retry;

    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_req_valid;
    logic              mem_req_retry;

    logic [LINE_W-1:0] mem_ack_data;
    logic              mem_ack_valid;
    logic              mem_ack_retry;

    logic [LINE_W-1:0] ic_ack_data;
    logic              ic_ack_valid;
    logic              ic_ack_retry;
    logic [LINE_W-1:0] dc_ack_data;
    logic              dc_ack_valid;
    logic              dc_ack_retry;

    modport slave (
        input  ic_req_addr, ic_req_valid,
        output ic_req_retry,
        input  dc_req_addr, dc_req_we, dc_req_data, dc_req_valid,
        output dc_req_retry,
        output mem_req_addr, mem_req_we, mem_req_data, mem_req_valid,
        input  mem_req_retry,
        input  mem_ack_data, mem_ack_valid,
        output mem_ack_retry,
        output ic_ack_data, ic_ack_valid,
        input  ic_ack_retry,
        output dc_ack_data, dc_ack_valid,
        input  dc_ack_retry
    );

    modport master (
        output ic_req_addr, ic_req_valid,
        input  ic_req_retry,
        output dc_req_addr, dc_req_we, dc_req_data, dc_req_valid,
        input  dc_req_retry,
        input  mem_req_addr, mem_req_we, mem_req_data, mem_req_valid,
        output mem_req_retry,
        output mem_ack_data, mem_ack_valid,
        input  mem_ack_retry,
        input  ic_ack_data, ic_ack_valid,
        output ic_ack_retry,
        input  dc_ack_data, dc_ack_valid,
        output dc_ack_retry
    );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between icache and dcache, one transaction in flight.
//   state | meaning
//   IDLE  | free; grant a valid requester and latch its payload
//   ISSUE | present request to memory until accepted
//   WAIT  | accept the memory ack and latch the returned line
//   RESP  | present the line to the original requester until accepted
module mem_arb #(
    parameter int ADDR_W = 59,
    parameter int LINE_W = 256
) (
    input logic     clk,
    input logic     reset,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              last_dc_q;
    logic              src_dc_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic [LINE_W-1:0] rsp_q;
    logic              mem_req_valid_q;
    logic              mem_ack_retry_q;
    logic              ic_ack_valid_q;
    logic              dc_ack_valid_q;

    logic grant_ic_d;
    logic grant_dc_d;
    logic src_ack_retry_d;

    // dcache wins a tie unless it was the last one served
    always_comb begin
        grant_dc_d = 1'b0;
        grant_ic_d = 1'b0;
        if (state_q == IDLE) begin
            grant_dc_d = bus.dc_req_valid && (!bus.ic_req_valid || !last_dc_q);
            grant_ic_d = bus.ic_req_valid && !grant_dc_d;
        end
        src_ack_retry_d = src_dc_q ? bus.dc_ack_retry : bus.ic_ack_retry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            last_dc_q       <= 1'b0;
            src_dc_q        <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            rsp_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_ack_retry_q <= 1'b1;
            ic_ack_valid_q  <= 1'b0;
            dc_ack_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ic_d || grant_dc_d) begin
                        state_q         <= ISSUE;
                        src_dc_q        <= grant_dc_d;
                        last_dc_q       <= grant_dc_d;
                        addr_q          <= grant_dc_d ? bus.dc_req_addr : bus.ic_req_addr;
                        we_q            <= grant_dc_d && bus.dc_req_we;
                        data_q          <= grant_dc_d ? bus.dc_req_data : '0;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!bus.mem_req_retry) begin
                        state_q         <= WAIT;
                        mem_req_valid_q <= 1'b0;
                        mem_ack_retry_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack_valid) begin
                        state_q         <= RESP;
                        rsp_q           <= bus.mem_ack_data;
                        mem_ack_retry_q <= 1'b1;
                        ic_ack_valid_q  <= !src_dc_q;
                        dc_ack_valid_q  <= src_dc_q;
                    end
                end
                RESP: begin
                    if (!src_ack_retry_d) begin
                        state_q        <= IDLE;
                        ic_ack_valid_q <= 1'b0;
                        dc_ack_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs are forced to their idle values while reset is held low.
    assign bus.ic_req_retry  = !(reset && grant_ic_d);
    assign bus.dc_req_retry  = !(reset && grant_dc_d);
    assign bus.mem_req_valid = reset && mem_req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_data  = data_q;
    assign bus.mem_ack_retry = !reset || mem_ack_retry_q;
    assign bus.ic_ack_valid  = reset && ic_ack_valid_q;
    assign bus.dc_ack_valid  = reset && dc_ack_valid_q;
    assign bus.ic_ack_data   = rsp_q;
    assign bus.dc_ack_data   = rsp_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a transaction-level model checks every cycle, plus literal spot checks.
module tb_mem_arb;
    localparam int AW = 59;
    localparam int LW = 256;

    logic clk;
    logic reset;

    mem_arb_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_arb #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one record, progressing granted -> sent -> answered -> delivered.
    logic          have_txn = 1'b0;
    logic          sent     = 1'b0;
    logic          answered = 1'b0;
    logic          last_dc  = 1'b0;
    logic          m_src_dc = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic          m_we     = 1'b0;
    logic [LW-1:0] m_data   = '0;
    logic [LW-1:0] m_rsp    = '0;
    int            n_mem_xfer = 0;

    always @(negedge clk) begin
        logic ic_win, dc_win;
        ic_win = 1'b0;
        dc_win = 1'b0;
        if (!reset) begin
            chk("rst_mem_req_valid", bus.mem_req_valid, 0);
            chk("rst_ic_ack_valid",  bus.ic_ack_valid, 0);
            chk("rst_dc_ack_valid",  bus.dc_ack_valid, 0);
            chk("rst_ic_req_retry",  bus.ic_req_retry, 1);
            chk("rst_dc_req_retry",  bus.dc_req_retry, 1);
            chk("rst_mem_ack_retry", bus.mem_ack_retry, 1);
            have_txn = 1'b0;
            sent     = 1'b0;
            answered = 1'b0;
            last_dc  = 1'b0;
        end else begin
            if (!have_txn) begin
                dc_win = bus.dc_req_valid && (!bus.ic_req_valid || !last_dc);
                ic_win = bus.ic_req_valid && !dc_win;
            end
            chk("ic_req_retry",  bus.ic_req_retry, !ic_win);
            chk("dc_req_retry",  bus.dc_req_retry, !dc_win);
            chk("mem_req_valid", bus.mem_req_valid, have_txn && !sent);
            chk("mem_ack_retry", bus.mem_ack_retry, !(sent && !answered));
            chk("ic_ack_valid",  bus.ic_ack_valid, answered && !m_src_dc);
            chk("dc_ack_valid",  bus.dc_ack_valid, answered && m_src_dc);
            if (have_txn && !sent) begin
                chk("mem_req_addr", bus.mem_req_addr, m_addr);
                chk("mem_req_we",   bus.mem_req_we, m_we);
                chk("mem_req_data", bus.mem_req_data, m_data);
            end
            if (answered) chk("ack_data", m_src_dc ? bus.dc_ack_data : bus.ic_ack_data, m_rsp);

            if (!have_txn) begin
                if (ic_win || dc_win) begin
                    have_txn = 1'b1;
                    m_src_dc = dc_win;
                    last_dc  = dc_win;
                    m_addr   = dc_win ? bus.dc_req_addr : bus.ic_req_addr;
                    m_we     = dc_win ? bus.dc_req_we : 1'b0;
                    m_data   = dc_win ? bus.dc_req_data : '0;
                end
            end else if (!sent) begin
                if (!bus.mem_req_retry) begin
                    sent = 1'b1;
                    n_mem_xfer++;
                end
            end else if (!answered) begin
                if (bus.mem_ack_valid) begin
                    answered = 1'b1;
                    m_rsp    = bus.mem_ack_data;
                end
            end else if (!(m_src_dc ? bus.dc_ack_retry : bus.ic_ack_retry)) begin
                have_txn = 1'b0;
                sent     = 1'b0;
                answered = 1'b0;
            end
        end
    end

    // Memory responder: acks each accepted request mem_delay cycles later with mem_rsp.
    logic          auto_mem  = 1'b1;
    int            mem_delay = 0;
    logic [LW-1:0] mem_rsp   = '0;

    always begin
        @(negedge clk);
        if (auto_mem && reset && bus.mem_req_valid && !bus.mem_req_retry) begin
            repeat (mem_delay + 1) @(posedge clk);
            #1;
            bus.mem_ack_valid = 1'b1;
            bus.mem_ack_data  = mem_rsp;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!bus.mem_ack_retry) break;
            end
            @(posedge clk);
            #1;
            bus.mem_ack_valid = 1'b0;
        end
    end

    function automatic logic probe(input int w);
        case (w)
            0:       return bus.mem_req_valid;
            1:       return bus.ic_ack_valid;
            default: return bus.dc_ack_valid;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int w, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (probe(w)) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL timeout %s: event not seen within %0d cycles", nm, budget);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int x0;
        int held;
        logic seen;
        logic [LW-1:0] wb;
        wb = {(LW/8){8'hA5}};

        reset             = 1'b0;
        bus.ic_req_addr   = '0;
        bus.ic_req_valid  = 1'b0;
        bus.dc_req_addr   = '0;
        bus.dc_req_we     = 1'b0;
        bus.dc_req_data   = '0;
        bus.dc_req_valid  = 1'b0;
        bus.mem_req_retry = 1'b0;
        bus.mem_ack_data  = '0;
        bus.mem_ack_valid = 1'b0;
        bus.ic_ack_retry  = 1'b0;
        bus.dc_ack_retry  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_ack_retry_lit", bus.mem_ack_retry, 1);
        chk("reset_mem_req_valid_lit", bus.mem_req_valid, 0);
        step();

        // tie after reset: dcache first, then icache
        reset            = 1'b1;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = AW'('h10);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = AW'('h20);
        mem_rsp          = LW'('hD1);
        @(negedge clk);
        chk("tie_dc_granted", bus.dc_req_retry, 0);
        chk("tie_ic_retried", bus.ic_req_retry, 1);
        step();
        bus.dc_req_valid = 1'b0;
        @(negedge clk);
        chk("tie_mem_valid_next", bus.mem_req_valid, 1);
        chk("tie_mem_addr_dc", bus.mem_req_addr, AW'('h10));
        wait_for("dc_ack_1", 2, 20);
        chk("dc_ack_data_1", bus.dc_ack_data, LW'('hD1));
        mem_rsp = LW'('hE2);
        @(negedge clk);
        chk("ic_granted_second", bus.ic_req_retry, 0);
        step();
        bus.ic_req_valid = 1'b0;
        wait_for("ic_mem_req", 0, 10);
        chk("ic_mem_addr", bus.mem_req_addr, AW'('h20));
        chk("ic_mem_we_zero", bus.mem_req_we, 0);
        wait_for("ic_ack_1", 1, 20);
        chk("ic_ack_data_1", bus.ic_ack_data, LW'('hE2));
        step();

        // writeback held under memory backpressure
        x0 = n_mem_xfer;
        bus.mem_req_retry = 1'b1;
        bus.dc_req_valid  = 1'b1;
        bus.dc_req_we     = 1'b1;
        bus.dc_req_addr   = AW'('h33);
        bus.dc_req_data   = wb;
        mem_rsp           = LW'('h77);
        @(negedge clk);
        step();
        bus.dc_req_valid = 1'b0;
        bus.dc_req_we    = 1'b0;
        bus.dc_req_data  = '0;
        held = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.mem_req_valid) break;
            held++;
            chk("wb_addr_stable", bus.mem_req_addr, AW'('h33));
            chk("wb_we_stable", bus.mem_req_we, 1);
            chk("wb_data_stable", bus.mem_req_data, wb);
            step();
            if (held == 3) bus.mem_req_retry = 1'b0;
        end
        chk("wb_held_cycles", held, 4);
        wait_for("wb_ack", 2, 20);
        chk("wb_ack_data", bus.dc_ack_data, LW'('h77));
        chk("wb_one_xfer", n_mem_xfer - x0, 1);
        step();

        // icache read with slow memory
        mem_delay        = 5;
        mem_rsp          = LW'('h1234);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = AW'('h40);
        step();
        bus.ic_req_valid = 1'b0;
        wait_for("ic_slow_ack", 1, 30);
        chk("ic_slow_data", bus.ic_ack_data, LW'('h1234));
        chk("ic_slow_no_dc", bus.dc_ack_valid, 0);
        mem_delay = 0;
        step();

        // stray memory ack while idle
        bus.mem_ack_valid = 1'b1;
        bus.mem_ack_data  = LW'('hBEEF);
        @(negedge clk);
        chk("stray_ack_retry", bus.mem_ack_retry, 1);
        chk("stray_no_ic_ack", bus.ic_ack_valid, 0);
        chk("stray_no_dc_ack", bus.dc_ack_valid, 0);
        step();
        bus.mem_ack_valid = 1'b0;
        step();

        // reset while waiting on memory discards the transaction
        auto_mem         = 1'b0;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = AW'('h50);
        step();
        bus.dc_req_valid = 1'b0;
        wait_for("rst_mid_req", 0, 10);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack_retry", bus.mem_ack_retry, 1);
        step();
        reset             = 1'b1;
        bus.mem_ack_valid = 1'b1;
        bus.mem_ack_data  = LW'('hBAD);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen = seen | bus.dc_ack_valid | bus.ic_ack_valid;
            step();
        end
        chk("rst_mid_no_ack", seen, 0);
        bus.mem_ack_valid = 1'b0;
        auto_mem          = 1'b1;
        mem_rsp           = LW'('h600);
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = AW'('h60);
        step();
        bus.ic_req_valid = 1'b0;
        wait_for("post_rst_req", 0, 10);
        chk("post_rst_addr", bus.mem_req_addr, AW'('h60));
        wait_for("post_rst_ack", 1, 20);
        chk("post_rst_data", bus.ic_ack_data, LW'('h600));
        step();

        // icache holds off its response; a waiting dcache request must not be granted
        bus.ic_ack_retry = 1'b1;
        mem_rsp          = LW'('h7070);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = AW'('h70);
        step();
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = AW'('h80);
        wait_for("hold_ic_ack", 1, 20);
        chk("hold_data_1", bus.ic_ack_data, LW'('h7070));
        chk("hold_dc_blocked_1", bus.dc_req_retry, 1);
        step();
        @(negedge clk);
        chk("hold_valid_2", bus.ic_ack_valid, 1);
        chk("hold_data_2", bus.ic_ack_data, LW'('h7070));
        chk("hold_dc_blocked_2", bus.dc_req_retry, 1);
        step();
        bus.ic_ack_retry = 1'b0;
        mem_rsp          = LW'('h8080);
        @(negedge clk);
        chk("hold_release_valid", bus.ic_ack_valid, 1);
        chk("hold_dc_blocked_3", bus.dc_req_retry, 1);
        step();
        @(negedge clk);
        chk("dc_granted_after_resp", bus.dc_req_retry, 0);
        step();
        bus.dc_req_valid = 1'b0;
        wait_for("after_hold_req", 0, 10);
        chk("after_hold_addr", bus.mem_req_addr, AW'('h80));
        wait_for("after_hold_ack", 2, 20);
        chk("after_hold_data", bus.dc_ack_data, LW'('h8080));
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
